instr_imm_stage: RTL and testbench
==================================

INSTR_IMM_STAGE -- requirements
Module: instr_imm_stage

Interface
REQ-001 Parameter W, default 32, instruction word width in bits.
REQ-002 Parameter N, default 16, immediate field width in bits, N <= W.
REQ-003 Reset is asynchronous and active-low: port rst clears all state immediately while low. A single clock, clk, is used.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 in_instr  input  W  instruction word from fetch.
REQ-007 in_fmt  input  2  field select: 00 = instr[N-1:0]; 01 = instr[W-1:W-N]; 10 = all-zero; 11 = illegal.
REQ-008 in_valid  input  1  upstream word/fmt valid.
REQ-009 in_ready  output  1  stage can accept this cycle.
REQ-010 out_imm  output  N  extracted field, fed to the sign extender's data input.
REQ-011 out_valid  output  1  out_imm holds an unconsumed field.
REQ-012 out_ready  input  1  downstream consumes out_imm this cycle.
REQ-013 ext_hiz  output  1  drives the sign extender's tri-state enable; equals !out_valid.
REQ-014 ext_act  output  1  drives the sign extender's active-high run input; equals out_valid.
REQ-015 xfer_cnt  output  8  count of completed output transfers.
REQ-016 fmt_err  output  1  sticky flag, set by an accepted in_fmt = 11.

Function
REQ-017 Input transfer occurs on a rising clk when in_valid && in_ready. Output transfer occurs on a rising clk when out_valid && out_ready.
REQ-018 Field extraction happens at acceptance per in_fmt. Extraction for fmt 11 yields all-zero.
REQ-019 The stage preserves order and never drops or duplicates a field.
REQ-020 Latency: an accepted word appears on out_imm with out_valid = 1 in the next cycle when the output is empty.
REQ-021 out_imm and out_valid come straight from registers, with no combinational path from in_* to out_*.
REQ-022 out_imm stays stable while out_valid && !out_ready.
REQ-023 ext_hiz and ext_act are decoded directly from the out_valid register.
REQ-024 xfer_cnt increments by 1 per output transfer and wraps from 255 to 0.
REQ-025 fmt_err sets on an accepted fmt 11 and clears only on reset.
REQ-026 Simultaneous input and output transfer in the same cycle: the count of occupied entries is unchanged and the new field queues behind the held one.

Reset
REQ-027 While rst = 0: out_valid = 0, out_imm = 0, xfer_cnt = 0, fmt_err = 0, ext_hiz = 1, ext_act = 0, all buffers empty.
REQ-028 in_ready = 0 while rst = 0. After deassertion, in_ready = 1 from the first clk edge.
REQ-029 Reset mid-transfer discards all held fields. No transfer completes in the cycle rst is low.

Configuration
REQ-030 Macro IMM_SKID_EN.
- When defined: a 2-entry skid buffer. in_ready is registered and equals "skid entry empty". Full throughput is sustained under out_ready = 1. With out_ready = 0, at most 2 fields are held; a third in_valid sees in_ready = 0.
- When undefined: a single register. in_ready = !out_valid || out_ready (combinational). At most 1 field is held.

Verification
REQ-031 Reset: rst = 0 mid-stream with 2 fields held -> out_valid = 0, xfer_cnt = 0, ext_hiz = 1 the same cycle. After release, in_ready = 1 on the next edge.
REQ-032 Extraction: in_instr = 0x8ABC_1234 with fmt 00, 01, 10 -> out_imm = 0x1234, 0x8ABC, 0x0000 in order, with ext_act = 1 each cycle.
REQ-033 Illegal format: fmt 11 accepted -> out_imm = 0x0000 and fmt_err = 1. fmt_err stays 1 through 10 further legal transfers.
REQ-034 Back-pressure: out_ready = 0, in_valid held high -> with IMM_SKID_EN, in_ready drops after 2 accepts; without it, after 1. Releasing out_ready drains the fields in order and out_imm is stable while stalled.
REQ-035 Throughput and wrap: 300 consecutive words with out_ready = 1 (IMM_SKID_EN defined) -> one transfer per cycle after the first, and xfer_cnt = 44 (300 mod 256) at the end.
REQ-036 Simultaneous events: output holds 1 field, in_valid && out_ready in the same cycle -> out_valid stays 1, the next field appears the following cycle, and no field is lost.

Source files
------------

// File: rtl/instr_imm_stage.sv
// instr_imm_stage: immediate-field extraction stage between fetch and the
// sign extender. Accepts an instruction word plus a field select, extracts
// the N-bit field at acceptance and presents it from registers downstream
// with a valid/ready handshake. Also counts output transfers and keeps a
// sticky flag for the illegal field select.
//
// Optional feature: define IMM_SKID_EN to build a 2-entry skid buffer with a
// registered in_ready. Without it the stage is a single register whose
// in_ready is combinational.
module instr_imm_stage #(
    parameter int W = 32,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_instr,
    input  logic [1:0]   in_fmt,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_imm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ext_hiz,
    output logic         ext_act,
    output logic [7:0]   xfer_cnt,
    output logic         fmt_err
);

    typedef enum logic [1:0] {
        FMT_LO   = 2'b00,
        FMT_HI   = 2'b01,
        FMT_ZERO = 2'b10,
        FMT_ILL  = 2'b11
    } fmt_e;

    logic         accept;
    logic         pop;
    logic [N-1:0] new_imm;

    function automatic logic [N-1:0] extract(input logic [W-1:0] instr, input fmt_e fmt);
        logic [N-1:0] f;
        // NOTE: default the result first so no path leaves it unassigned; in
        // combinational logic that is what keeps a latch from being inferred.
        f = '0;
        case (fmt)
            FMT_LO:  f = instr[N-1:0];
            FMT_HI:  f = instr[W-1:W-N];
            default: f = '0;
        endcase
        return f;
    endfunction

    // Handshake decode and field extraction at the input boundary
    always_comb begin
        accept  = in_valid && in_ready;
        pop     = out_valid && out_ready;
        new_imm = extract(in_instr, fmt_e'(in_fmt));
    end

    // Output transfer counter, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt <= 8'd0;
        end else if (pop) begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            xfer_cnt <= xfer_cnt + 8'd1;
        end
    end

    // Sticky illegal-format flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fmt_err <= 1'b0;
        end else if (accept && (fmt_e'(in_fmt) == FMT_ILL)) begin
            fmt_err <= 1'b1;
        end
    end

    // Sign-extender controls decoded straight from the out_valid register
    assign ext_hiz = !out_valid;
    assign ext_act = out_valid;

`ifdef IMM_SKID_EN
    logic         skid_valid;
    logic         skid_next;
    logic [N-1:0] skid_imm;

    // Skid entry is occupied only while the output register is stalled
    always_comb begin
        skid_next = 1'b0;
        if (out_valid && !out_ready) begin
            skid_next = skid_valid || accept;
        end
    end

    // Output register refills from the skid entry first, then from the input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            if (!out_valid || out_ready) begin
                if (skid_valid) begin
                    out_imm   <= skid_imm;
                    out_valid <= 1'b1;
                end else if (accept) begin
                    out_imm   <= new_imm;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            skid_valid <= skid_next;
            in_ready   <= !skid_next;
        end
    end

    // Skid payload captures the incoming field while the output is stalled
    always_ff @(posedge clk) begin
        // NOTE: payload storage is left unreset; skid_valid qualifies it, so
        // its power-up contents are never observed.
        if (accept && out_valid && !out_ready) begin
            skid_imm <= new_imm;
        end
    end
`else
    logic ready_en;

    // Holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign in_ready = ready_en && (!out_valid || out_ready);

    // Single output register: load on accept, empty on a lone pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
        end else if (accept) begin
            out_imm   <= new_imm;
            out_valid <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_instr_imm_stage.sv
// Scoreboard bench for instr_imm_stage: directed vectors push their expected
// field into a queue on acceptance; a negedge monitor pops and compares on
// every output transfer and tracks stall stability and transfer count.
module tb_instr_imm_stage;

    localparam int W = 32;
    localparam int N = 16;
`ifdef IMM_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_instr = '0;
    logic [1:0]   in_fmt = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] out_imm;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         ext_hiz;
    logic         ext_act;
    logic [7:0]   xfer_cnt;
    logic         fmt_err;

    always #5 clk = ~clk;

    instr_imm_stage #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_instr  (in_instr),
        .in_fmt    (in_fmt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_imm   (out_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext_hiz   (ext_hiz),
        .ext_act   (ext_act),
        .xfer_cnt  (xfer_cnt),
        .fmt_err   (fmt_err)
    );

    int           n_tests = 0;
    int           n_fail = 0;
    logic [N-1:0] scb[$];
    logic [N-1:0] mon_exp;
    int           exp_xfer = 0;
    int           run_len = 0;
    int           max_run = 0;
    int           stall_cnt = 0;
    logic         held_valid = 1'b0;
    logic [N-1:0] held_imm = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every output transfer against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            held_valid = 1'b0;
            run_len    = 0;
        end else begin
            if (out_valid && held_valid)
                check("stall_stable", 32'(out_imm), 32'(held_imm));
            if (out_valid && out_ready) begin
                check("pop_ext_act", 32'(ext_act), 32'd1);
                check("pop_ext_hiz", 32'(ext_hiz), 32'd0);
                if (scb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, want no output", out_imm);
                end else begin
                    mon_exp = scb.pop_front();
                    check("out_imm", 32'(out_imm), 32'(mon_exp));
                end
                exp_xfer = (exp_xfer + 1) % 256;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            held_valid = out_valid && !out_ready;
            held_imm   = out_imm;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one word until accepted (bounded), pushing its expected field
    task automatic send(input logic [W-1:0] instr, input logic [1:0] fmt, input logic [N-1:0] exp_imm);
        int waited = 0;
        bit done = 1'b0;
        in_instr = instr;
        in_fmt   = fmt;
        in_valid = 1'b1;
        while (!done && waited < 20) begin
            @(negedge clk);
            if (in_ready) begin
                scb.push_back(exp_imm);
                done = 1'b1;
            end else begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no accept in 20 cycles, want accept of 0x%0h", instr);
        end
    endtask

    // Hold in_valid high for 4 cycles with out_ready low, counting accepts
    task automatic fill_stalled(output int acc);
        logic [W-1:0] words[4];
        logic [N-1:0] exps[4];
        words = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        exps  = '{16'h0001, 16'hBBBB, 16'h0003, 16'hDDDD};
        acc = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_instr = words[acc];
            in_fmt   = (acc % 2 == 0) ? 2'b00 : 2'b01;
            @(negedge clk);
            if (in_ready) begin
                scb.push_back(exps[acc]);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           acc;
        logic [W-1:0] w;
        logic [1:0]   f;
        logic [N-1:0] e;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm", 32'(out_imm), 32'd0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        check("rst_fmt_err", 32'(fmt_err), 32'd0);
        check("rst_ext_hiz", 32'(ext_hiz), 32'd1);
        check("rst_ext_act", 32'(ext_act), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("release_in_ready_pre_edge", 32'(in_ready), 32'd0);
        idle(1);
        check("release_in_ready", 32'(in_ready), 32'd1);

        // Extraction for each legal format
        out_ready = 1'b1;
        send(32'h8ABC_1234, 2'b00, 16'h1234);
        check("ext_act_lo", 32'(ext_act), 32'd1);
        send(32'h8ABC_1234, 2'b01, 16'h8ABC);
        check("ext_act_hi", 32'(ext_act), 32'd1);
        send(32'h8ABC_1234, 2'b10, 16'h0000);
        check("ext_act_zero", 32'(ext_act), 32'd1);
        idle(2);
        check("extract_drained", 32'(scb.size()), 32'd0);
        check("idle_ext_hiz", 32'(ext_hiz), 32'd1);
        check("extract_xfer", 32'(xfer_cnt), 32'(exp_xfer));

        // Back-pressure: capacity, stall stability, ordered drain
        fill_stalled(acc);
        check("bp_accepts", 32'(acc), 32'(CAP));
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        idle(3);
        out_ready = 1'b1;
        idle(4);
        check("bp_drained", 32'(scb.size()), 32'd0);
        check("bp_xfer", 32'(xfer_cnt), 32'(exp_xfer));

        // Simultaneous input and output transfer
        out_ready = 1'b0;
        send(32'h1111_2222, 2'b00, 16'h2222);
        check("sim_held", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        send(32'h3333_4444, 2'b01, 16'h3333);
        check("sim_out_valid", 32'(out_valid), 32'd1);
        check("sim_out_imm", 32'(out_imm), 32'h3333);
        idle(2);
        check("sim_drained", 32'(scb.size()), 32'd0);
        check("sim_empty", 32'(out_valid), 32'd0);

        // Illegal format, then 10 legal transfers with the flag held
        send(32'hFFFF_FFFF, 2'b11, 16'h0000);
        check("fmt_err_set", 32'(fmt_err), 32'd1);
        for (int i = 0; i < 10; i++) begin
            w = {16'hC000 + 16'(i), 16'h0100 + 16'(i)};
            f = (i % 2 == 0) ? 2'b00 : 2'b01;
            e = (i % 2 == 0) ? (16'h0100 + 16'(i)) : (16'hC000 + 16'(i));
            send(w, f, e);
        end
        idle(2);
        check("fmt_err_sticky", 32'(fmt_err), 32'd1);
        check("fmt_xfer", 32'(xfer_cnt), 32'(exp_xfer));

        // Reset mid-stream with fields held
        fill_stalled(acc);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_imm", 32'(out_imm), 32'd0);
        check("mid_rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        check("mid_rst_ext_hiz", 32'(ext_hiz), 32'd1);
        check("mid_rst_fmt_err", 32'(fmt_err), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        scb.delete();
        exp_xfer = 0;
        idle(2);
        rst = 1'b1;
        #1;
        check("mid_release_pre_edge", 32'(in_ready), 32'd0);
        idle(1);
        check("mid_release_in_ready", 32'(in_ready), 32'd1);
        check("mid_release_empty", 32'(out_valid), 32'd0);

        // Throughput and counter wrap over 300 back-to-back words
        out_ready = 1'b1;
        max_run   = 0;
        stall_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            w = {16'(i) ^ 16'hA5A5, 16'(i)};
            f = 2'(i % 3);
            case (f)
                2'b00:   e = 16'(i);
                2'b01:   e = 16'(i) ^ 16'hA5A5;
                default: e = 16'h0000;
            endcase
            send(w, f, e);
        end
        idle(3);
        check("tp_stalls", 32'(stall_cnt), 32'd0);
        check("tp_run", 32'(max_run), 32'd300);
        check("tp_xfer_wrap", 32'(xfer_cnt), 32'd44);
        check("tp_drained", 32'(scb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
